rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single write port of the 8x16-bit register file between two writeback requesters: port 0 (ALU) and port 1 (memory load).
- Each requester has a one-entry holding register behind a valid/ready handshake.
- An arbiter drains the holding registers into the register file write port and keeps write-after-write order for the same register.
- Publishes a busy scoreboard so decode can detect registers with pending writes.

Parameters:
- NREG, 8, number of architectural registers; must equal 2**SELW.
- SELW, 3, register select width.
- DW, 16, data width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  ALU writeback request.
- req0_ready  out  1  ALU request accepted this cycle when valid&ready.
- req0_sel  in  SELW  ALU destination register.
- req0_data  in  DW  ALU writeback data.
- req1_valid  in  1  memory writeback request.
- req1_ready  out  1  memory request accepted when valid&ready.
- req1_sel  in  SELW  memory destination register.
- req1_data  in  DW  memory writeback data.
- stall  in  1  register file write port unavailable this cycle.
- writeEn  out  1  register file write enable.
- writeRegSel  out  SELW  register file write select.
- writeData  out  DW  register file write data.
- busy  out  NREG  bit r=1 while any holding register targets r.
- idle  out  1  both holding registers empty.

Behaviour:
- State:
  - hold_v[1:0], hold_sel[i], hold_data[i].
  - old: which holding register was loaded first.
  - rr: round-robin pointer.
- Reset (rst=0, asynchronous):
  - hold_v=0, old=0, rr=0.
  - writeEn=0 immediately; busy=0; idle=1; req0_ready=req1_ready=1.
  - Pending writes are discarded.
- Accept:
  - req_i_ready = ~hold_v[i] | gnt[i].
  - On valid&ready at edge N, hold_i loads sel and data and hold_v[i] is set.
  - Earliest register file write is at edge N+1. Latency is one cycle and throughput is one write per cycle.
- Grant (combinational, from holding registers only, never from request inputs):
  - If stall=1 or no hold_v: gnt=0.
  - If exactly one hold_v: grant that one.
  - If both hold_v and hold_sel[0]==hold_sel[1]: grant hold[old].
  - If both hold_v and the selects differ: grant hold[rr].
- Write port: writeEn=|gnt; writeRegSel/writeData come from the granted holding register; they are 0 when writeEn=0.
- Update at edge:
  - The granted hold_v clears, unless it is reloaded in the same cycle (req_ready via gnt).
  - After a grant to i, rr=~i.
- Age tracking (old):
  - If only one holding register is occupied after the edge, old points to it.
  - If both load in the same cycle, old=0 (ALU is older).
  - If one loads while the other remains occupied, old points to the remaining one.
- busy[r] = (hold_v[0]&hold_sel[0]==r) | (hold_v[1]&hold_sel[1]==r). It is combinational from state.
- idle = ~|hold_v.
- stall held high: no writes; full holding registers keep their contents and deassert ready; empty ones still accept.
- Simultaneous accept and grant on the same port: the old entry is written and the new entry is loaded at the same edge.

Optional Feature:
- Macro RF_WB_FWD_EN.
- When defined, adds inputs fwdSel1/fwdSel2 (SELW) and outputs fwdHit1/fwdHit2 (1) and fwdData1/fwdData2 (DW).
- fwdHitK=1 when a holding register holds fwdSelK; fwdDataK is that entry's data.
- If both holding registers match, the younger entry (~old) supplies the data.
- fwdDataK=0 on a miss.
- When the macro is undefined, these ports do not exist and the behaviour above is unchanged.

Test Plan:
- Reset then idle: rst=0 -> writeEn=0, busy=8'h00, idle=1, both ready=1. After release with no requests, outputs are unchanged.
- Single write: req0 valid with sel=3, data=16'hABCD at edge N.
  - After edge N: busy=8'h08, writeEn=1, writeRegSel=3, writeData=16'hABCD.
  - After edge N+1: busy=0, idle=1.
- Round-robin: both ports request every cycle with different selects (port0 sel=1, port1 sel=2).
  - Grants alternate 0,1,0,1 starting with port 0 after reset.
  - Each port sees ready every other cycle; no data is lost.
- Same-register order: port1 loads sel=5, data=16'h1111 at edge N while stall=1. Port0 loads sel=5, data=16'h2222 at edge N+1.
  - Drop stall: write 16'h1111 first, then 16'h2222; final r5=16'h2222.
  - Repeat with both loaded in the same cycle: port0 data is written first.
- Stall: fill both holding registers, hold stall=1 for 4 cycles.
  - writeEn=0 and ready=0 on both ports; busy is stable.
  - After stall drops, two writes occur on consecutive cycles.
- Reset mid-operation: both holding registers full, assert rst between clock edges.
  - writeEn, busy and idle update without waiting for a clock edge.
  - After release, no stale write ever appears.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-port writeback arbiter with one-entry holding registers feeding the register file write port.
// Optional forwarding lookup of the holding registers is enabled by defining RF_WB_FWD_EN.
module rf_wb_arbiter #(
  parameter int NREG = 8,
  parameter int SELW = 3,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            rst,
`ifdef RF_WB_FWD_EN
  input  logic [SELW-1:0] fwdSel1,
  input  logic [SELW-1:0] fwdSel2,
  output logic            fwdHit1,
  output logic            fwdHit2,
  output logic [DW-1:0]   fwdData1,
  output logic [DW-1:0]   fwdData2,
`endif
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [SELW-1:0] req0_sel,
  input  logic [DW-1:0]   req0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [SELW-1:0] req1_sel,
  input  logic [DW-1:0]   req1_data,
  input  logic            stall,
  output logic            writeEn,
  output logic [SELW-1:0] writeRegSel,
  output logic [DW-1:0]   writeData,
  output logic [NREG-1:0] busy,
  output logic            idle
);
  logic [1:0]      holdV, gnt, acc, ready, nextV;
  logic [SELW-1:0] holdSel [2];
  logic [DW-1:0]   holdData [2];
  logic [SELW-1:0] reqSel [2];
  logic [DW-1:0]   reqData [2];
  logic            old, rr, oldNext, pick;
  assign reqSel[0]  = req0_sel;
  assign reqSel[1]  = req1_sel;
  assign reqData[0] = req0_data;
  assign reqData[1] = req1_data;
  // Same destination must drain oldest-first; otherwise alternate fairly.
  assign pick  = (holdSel[0] == holdSel[1]) ? old : rr;
  assign gnt   = stall ? 2'b00 : (&holdV) ? (pick ? 2'b10 : 2'b01) : holdV;
  assign ready = ~holdV | gnt;
  assign acc   = {req1_valid, req0_valid} & ready;
  assign nextV = acc | (holdV & ~gnt);
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign writeEn     = |gnt;
  assign writeRegSel = gnt[1] ? holdSel[1] : gnt[0] ? holdSel[0] : '0;
  assign writeData   = gnt[1] ? holdData[1] : gnt[0] ? holdData[0] : '0;
  assign idle        = ~|holdV;
  always_comb begin
    oldNext = nextV == 2'b10 ? 1'b1 : nextV == 2'b01 ? 1'b0 :
              acc == 2'b11 ? 1'b0 : acc == 2'b01 ? 1'b1 : acc == 2'b10 ? 1'b0 : old;
  end
  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG; r++)
      busy[r] = (holdV[0] && holdSel[0] == SELW'(r)) || (holdV[1] && holdSel[1] == SELW'(r));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      holdV       <= '0;
      old         <= 1'b0;
      rr          <= 1'b0;
      holdSel[0]  <= '0;
      holdSel[1]  <= '0;
      holdData[0] <= '0;
      holdData[1] <= '0;
    end else begin
      holdV <= nextV;
      old   <= oldNext;
      if (gnt[0]) rr <= 1'b1;
      if (gnt[1]) rr <= 1'b0;
      for (int i = 0; i < 2; i++)
        if (acc[i]) begin
          holdSel[i]  <= reqSel[i];
          holdData[i] <= reqData[i];
        end
    end
  end
`ifdef RF_WB_FWD_EN
  // When both entries match, the younger one carries the newest value.
  function automatic logic [DW:0] fwdLook(input logic [SELW-1:0] s);
    logic m0, m1;
    m0 = holdV[0] && holdSel[0] == s;
    m1 = holdV[1] && holdSel[1] == s;
    return {m0 | m1, (m0 & m1) ? holdData[~old] : m1 ? holdData[1] : m0 ? holdData[0] : '0};
  endfunction
  assign {fwdHit1, fwdData1} = fwdLook(fwdSel1);
  assign {fwdHit2, fwdData2} = fwdLook(fwdSel2);
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: scoreboard bench for rf_wb_arbiter; expected writes are queued by stimulus and popped by a write monitor.
module tb_rf_wb_arbiter;
  localparam int NREG = 8, SELW = 3, DW = 16;
  logic clk = 0, rst = 1, stall = 0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [SELW-1:0] req0_sel = 0, req1_sel = 0, writeRegSel;
  logic [DW-1:0] req0_data = 0, req1_data = 0, writeData;
  logic writeEn, idle;
  logic [NREG-1:0] busy;
  typedef struct packed {logic [SELW-1:0] sel; logic [DW-1:0] data;} wr_t;
  wr_t expQ[$];
  int checks = 0, errors = 0;

  rf_wb_arbiter #(.NREG(NREG), .SELW(SELW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel), .req1_data(req1_data),
    .stall(stall), .writeEn(writeEn), .writeRegSel(writeRegSel), .writeData(writeData),
    .busy(busy), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    rst = 0;
    tick;
    rst = 1;
  endtask

  // Write monitor: every register file write must match the next queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (rst && writeEn) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got sel=%0d data=%h expected no write", writeRegSel, writeData);
      end else begin
        e = expQ.pop_front();
        chk("write", {13'b0, writeRegSel, writeData}, {13'b0, e.sel, e.data});
      end
    end
  end

  initial begin
    int n0, n1;
    logic a0, a1;
    #1 rst = 0;
    #1;
    chk("rst_writeEn", writeEn, 0);
    chk("rst_busy", busy, 8'h00);
    chk("rst_idle", idle, 1);
    chk("rst_ready", {req0_ready, req1_ready}, 2'b11);
    tick; tick;
    rst = 1;
    tick; tick;
    chk("idle_after_release", {writeEn, busy, idle, req0_ready, req1_ready}, {1'b0, 8'h00, 3'b111});

    // single write
    req0_valid = 1; req0_sel = 3; req0_data = 16'hABCD;
    expQ.push_back('{3'd3, 16'hABCD});
    tick;
    req0_valid = 0;
    chk("single_busy", busy, 8'h08);
    chk("single_we", writeEn, 1);
    chk("single_sel", writeRegSel, 3);
    chk("single_data", writeData, 16'hABCD);
    tick;
    chk("single_busy_after", busy, 8'h00);
    chk("single_idle_after", idle, 1);

    // round-robin: both ports stream four writes each
    doReset;
    for (int k = 0; k < 4; k++) begin
      expQ.push_back('{3'd1, 16'hA000 + 16'(k)});
      expQ.push_back('{3'd2, 16'hB000 + 16'(k)});
    end
    n0 = 0; n1 = 0;
    req0_valid = 1; req0_sel = 1; req0_data = 16'hA000;
    req1_valid = 1; req1_sel = 2; req1_data = 16'hB000;
    for (int c = 0; c < 40 && !(n0 == 4 && n1 == 4); c++) begin
      @(negedge clk);
      a0 = req0_valid & req0_ready;
      a1 = req1_valid & req1_ready;
      if (req0_valid && req1_valid && !idle) chk("rr_ready_alternates", req0_ready ^ req1_ready, 1);
      tick;
      if (a0) begin n0++; if (n0 == 4) req0_valid = 0; else req0_data++; end
      if (a1) begin n1++; if (n1 == 4) req1_valid = 0; else req1_data++; end
    end
    req0_valid = 0; req1_valid = 0;
    chk("rr_accepts", n0 + n1, 8);
    for (int c = 0; c < 10 && !idle; c++) tick;
    chk("rr_idle", idle, 1);

    // same register, loaded in different cycles under stall
    stall = 1;
    req1_valid = 1; req1_sel = 5; req1_data = 16'h1111;
    tick;
    req1_valid = 0;
    req0_valid = 1; req0_sel = 5; req0_data = 16'h2222;
    tick;
    req0_valid = 0;
    chk("waw_busy", busy, 8'h20);
    chk("waw_stalled", writeEn, 0);
    expQ.push_back('{3'd5, 16'h1111});
    expQ.push_back('{3'd5, 16'h2222});
    stall = 0;
    tick; tick;
    chk("waw_idle", idle, 1);

    // same register, loaded in the same cycle
    expQ.push_back('{3'd5, 16'h3333});
    expQ.push_back('{3'd5, 16'h4444});
    req0_valid = 1; req0_sel = 5; req0_data = 16'h3333;
    req1_valid = 1; req1_sel = 5; req1_data = 16'h4444;
    tick;
    req0_valid = 0; req1_valid = 0;
    tick; tick;
    chk("waw2_idle", idle, 1);

    // stall with both holding registers full
    stall = 1;
    req0_valid = 1; req0_sel = 6; req0_data = 16'h6666;
    req1_valid = 1; req1_sel = 7; req1_data = 16'h7777;
    tick;
    req0_valid = 0; req1_valid = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("stall_we", writeEn, 0);
      chk("stall_ready", {req0_ready, req1_ready}, 2'b00);
      chk("stall_busy", busy, 8'hC0);
      tick;
    end
    expQ.push_back('{3'd6, 16'h6666});
    expQ.push_back('{3'd7, 16'h7777});
    stall = 0;
    #1;
    chk("unstall_we0", {writeEn, writeRegSel}, {1'b1, 3'd6});
    tick;
    chk("unstall_we1", {writeEn, writeRegSel}, {1'b1, 3'd7});
    tick;
    chk("unstall_idle", idle, 1);

    // asynchronous reset with both holding registers full
    stall = 1;
    req0_valid = 1; req0_sel = 0; req0_data = 16'h0A0A;
    req1_valid = 1; req1_sel = 4; req1_data = 16'h4B4B;
    tick;
    req0_valid = 0; req1_valid = 0;
    chk("pre_rst_busy", busy, 8'h11);
    stall = 0;
    #1;
    chk("pre_rst_we", writeEn, 1);
    rst = 0;
    #1;
    chk("async_rst_we", writeEn, 0);
    chk("async_rst_busy", busy, 8'h00);
    chk("async_rst_idle", idle, 1);
    chk("async_rst_ready", {req0_ready, req1_ready}, 2'b11);
    tick; tick;
    rst = 1;
    repeat (5) tick;
    chk("post_rst_idle", idle, 1);
    chk("queue_empty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
